// File: rtl/filter_pkg.sv
// rtl/filter_pkg.sv - shared 3x3 kernel constants and range-weight helper for the smoothing filters
package filter_pkg;

  localparam int CENTER_IDX   = 4;
  localparam int KERNEL_SHIFT = 4;

  localparam logic [2:0] SW_CORNER = 3'd1;
  localparam logic [2:0] SW_EDGE   = 3'd2;
  localparam logic [2:0] SW_CENTER = 3'd4;

  typedef enum logic [2:0] {
    RW_NONE = 3'd0,
    RW_FAR  = 3'd1,
    RW_MID  = 3'd2,
    RW_NEAR = 3'd4
  } range_w_e;

  function automatic logic [2:0] spatial_weight(input int k);
    case (k)
      0, 2, 6, 8: spatial_weight = SW_CORNER;
      1, 3, 5, 7: spatial_weight = SW_EDGE;
      default:    spatial_weight = SW_CENTER;
    endcase
  endfunction

  // One extra bit on every compare so 2*d and 2*sigma never wrap.
  function automatic range_w_e range_weight(input logic [15:0] d, input logic [15:0] sigma);
    logic [16:0] d2;
    logic [16:0] s2;
    d2 = {d, 1'b0};
    s2 = {sigma, 1'b0};
    if (d2 < {1'b0, sigma})
      range_weight = RW_NEAR;
    else if (d < sigma)
      range_weight = RW_MID;
    else if ({1'b0, d} < s2)
      range_weight = RW_FAR;
    else
      range_weight = RW_NONE;
  endfunction

endpackage

// File: rtl/bilateral_div.sv
// rtl/bilateral_div.sv - combinational round-half-up divider with clamp and zero-weight fallback
module bilateral_div #(
  parameter int PIXEL_WIDTH = 8
) (
  input  logic [PIXEL_WIDTH+5:0] num,
  input  logic [6:0]             den,
  input  logic [PIXEL_WIDTH-1:0] fallback,
  output logic [PIXEL_WIDTH-1:0] quot
);

  localparam int NW = PIXEL_WIDTH + 7;
  localparam logic [NW-1:0] PIX_MAX = NW'((1 << PIXEL_WIDTH) - 1);

  logic [NW-1:0] num_rnd;
  logic [NW-1:0] q_full;

  always_comb begin
    num_rnd = NW'(num) + NW'(den >> 1);
    q_full  = '0;
    quot    = fallback;
    if (den != 7'd0) begin
      q_full = num_rnd / NW'(den);
      quot   = (q_full > PIX_MAX) ? '1 : q_full[PIXEL_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/bilateral_filter.sv
// rtl/bilateral_filter.sv - 2-stage edge-preserving 3x3 filter replacing the window centre pixel
module bilateral_filter
  import filter_pkg::*;
#(
  parameter int PIXEL_WIDTH = 8,
  parameter int SIGMA_RANGE = 30
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     window_valid,
  input  logic [9*PIXEL_WIDTH-1:0] window_flat,
  output logic                     filter_valid,
  output logic [9*PIXEL_WIDTH-1:0] window_filtered
);

  localparam int PW = PIXEL_WIDTH;
  localparam int SW = PIXEL_WIDTH + 6;
  localparam int WW = 9 * PIXEL_WIDTH;

  logic          s1_valid_q, s1_valid_d;
  logic [WW-1:0] s1_window_q, s1_window_d;
  logic [6:0]    s1_wsum_q, s1_wsum_d;
  logic [SW-1:0] s1_psum_q, s1_psum_d;
  logic          filter_valid_q, filter_valid_d;
  logic [WW-1:0] window_filtered_q, window_filtered_d;

  logic [PW-1:0] centre;
  logic [PW-1:0] pix;
  logic [PW-1:0] diff;
  range_w_e      rw;
  logic [4:0]    w;
  logic [6:0]    wsum_c;
  logic [SW-1:0] psum_c;
  logic [PW-1:0] div_quot;

  // Stage 1: per-neighbour weights and the two accumulators.
  always_comb begin
    centre = window_flat[CENTER_IDX*PW +: PW];
    pix    = '0;
    diff   = '0;
    rw     = RW_NONE;
    w      = '0;
    wsum_c = '0;
    psum_c = '0;
    for (int k = 0; k < 9; k++) begin
      pix    = window_flat[k*PW +: PW];
      diff   = (pix >= centre) ? (pix - centre) : (centre - pix);
      rw     = range_weight(16'(diff), 16'(SIGMA_RANGE));
      w      = {2'b00, spatial_weight(k)} * {2'b00, rw};
      wsum_c = wsum_c + 7'(w);
      psum_c = psum_c + SW'(w) * SW'(pix);
    end
    s1_valid_d  = window_valid;
    s1_window_d = window_valid ? window_flat : s1_window_q;
    s1_wsum_d   = window_valid ? wsum_c : s1_wsum_q;
    s1_psum_d   = window_valid ? psum_c : s1_psum_q;
  end

  bilateral_div #(
    .PIXEL_WIDTH(PIXEL_WIDTH)
  ) u_div (
    .num     (s1_psum_q),
    .den     (s1_wsum_q),
    .fallback(s1_window_q[CENTER_IDX*PW +: PW]),
    .quot    (div_quot)
  );

  always_comb begin
    filter_valid_d    = s1_valid_q;
    window_filtered_d = window_filtered_q;
    if (s1_valid_q) begin
      window_filtered_d = s1_window_q;
      window_filtered_d[CENTER_IDX*PW +: PW] = div_quot;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q        <= 1'b0;
      s1_window_q       <= '0;
      s1_wsum_q         <= '0;
      s1_psum_q         <= '0;
      filter_valid_q    <= 1'b0;
      window_filtered_q <= '0;
    end else begin
      s1_valid_q        <= s1_valid_d;
      s1_window_q       <= s1_window_d;
      s1_wsum_q         <= s1_wsum_d;
      s1_psum_q         <= s1_psum_d;
      filter_valid_q    <= filter_valid_d;
      window_filtered_q <= window_filtered_d;
    end
  end

  assign filter_valid    = filter_valid_q;
  assign window_filtered = window_filtered_q;

endmodule

// File: tb/tb_bilateral_filter.sv
// tb/tb_bilateral_filter.sv - randomized self-checking bench for bilateral_filter against a behavioural model
module tb_bilateral_filter;

  localparam int SIGMA = 30;

  logic        clk;
  logic        rst_n;
  logic        window_valid;
  logic [71:0] window_flat;
  logic        filter_valid;
  logic [71:0] window_filtered;

  int n_checks;
  int n_fail;

  logic        h0_v, h1_v;
  logic [71:0] h0_w, h1_w;
  int          h0_cen, h1_cen;
  bit          h0_low, h1_low;
  logic [71:0] exp_hold;

  bilateral_filter #(
    .PIXEL_WIDTH(8),
    .SIGMA_RANGE(SIGMA)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .window_valid   (window_valid),
    .window_flat    (window_flat),
    .filter_valid   (filter_valid),
    .window_filtered(window_filtered)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int bil_ref(input logic [71:0] win);
    int sw[9];
    int p[9];
    int d, r, wsum, ssum, q;
    sw = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
    for (int k = 0; k < 9; k++) p[k] = int'(win[k*8 +: 8]);
    wsum = 0;
    ssum = 0;
    for (int k = 0; k < 9; k++) begin
      d = (p[k] > p[4]) ? p[k] - p[4] : p[4] - p[k];
      if (2 * d < SIGMA)      r = 4;
      else if (d < SIGMA)     r = 2;
      else if (d < 2 * SIGMA) r = 1;
      else                    r = 0;
      wsum += sw[k] * r;
      ssum += sw[k] * r * p[k];
    end
    if (wsum == 0) return p[4];
    q = (ssum + wsum / 2) / wsum;
    return (q > 255) ? 255 : q;
  endfunction

  function automatic int gauss_ref(input logic [71:0] win);
    int sw[9];
    int s;
    sw = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
    s = 0;
    for (int k = 0; k < 9; k++) s += sw[k] * int'(win[k*8 +: 8]);
    return (s + 8) / 16;
  endfunction

  function automatic logic [71:0] exp_window(input logic [71:0] win);
    logic [71:0] o;
    o = win;
    o[39:32] = 8'(bil_ref(win));
    return o;
  endfunction

  function automatic logic [71:0] pack9(input int p0, p1, p2, p3, p4, p5, p6, p7, p8);
    return {8'(p8), 8'(p7), 8'(p6), 8'(p5), 8'(p4), 8'(p3), 8'(p2), 8'(p1), 8'(p0)};
  endfunction

  // Each negedge checks the window driven two negedges earlier, then drives the next one.
  task automatic step(input logic v, input logic [71:0] win, input int cen, input bit low);
    @(negedge clk);
    if (h1_v) exp_hold = exp_window(h1_w);
    check_eq("filter_valid", 72'(filter_valid), 72'(h1_v));
    check_eq("window_filtered", window_filtered, exp_hold);
    if (h1_v && h1_cen >= 0) check_eq("centre_directed", 72'(window_filtered[39:32]), 72'(h1_cen));
    if (h1_v && h1_low) check_eq("gauss_equiv", 72'(window_filtered[39:32]), 72'(gauss_ref(h1_w)));
    h1_v = h0_v; h1_w = h0_w; h1_cen = h0_cen; h1_low = h0_low;
    h0_v = v;    h0_w = win;  h0_cen = cen;    h0_low = low;
    window_valid = v;
    window_flat  = win;
  endtask

  task automatic clear_hist();
    h0_v = 1'b0; h1_v = 1'b0; h0_w = '0; h1_w = '0;
    h0_cen = -1; h1_cen = -1; h0_low = 1'b0; h1_low = 1'b0;
    exp_hold = '0;
  endtask

  logic [71:0] w_uni, w_noise, w_sharp, w_nedge, w_weak, w_rnd;
  int mode, base, lo, hi;
  logic v_rnd;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n        = 1'b0;
    window_valid = 1'b0;
    window_flat  = '0;
    clear_hist();

    w_uni   = pack9(100, 100, 100, 100, 100, 100, 100, 100, 100);
    w_noise = pack9(96, 101, 99, 103, 100, 97, 102, 98, 105);
    w_sharp = pack9(200, 200, 50, 200, 200, 50, 50, 50, 50);
    w_nedge = pack9(201, 197, 53, 202, 198, 49, 51, 52, 48);
    w_weak  = pack9(130, 130, 100, 130, 130, 100, 100, 100, 100);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_valid", 72'(filter_valid), 72'(0));
    check_eq("reset_window", window_filtered, 72'(0));
    rst_n = 1'b1;

    step(1'b1, w_uni, 100, 1'b1);
    step(1'b0, w_uni, -1, 1'b0);
    step(1'b0, '0, -1, 1'b0);
    step(1'b0, '0, -1, 1'b0);

    step(1'b1, w_noise, 100, 1'b1);
    step(1'b1, w_sharp, 200, 1'b0);
    step(1'b1, w_nedge, 199, 1'b0);
    step(1'b1, w_weak, 125, 1'b0);
    step(1'b0, '0, -1, 1'b0);
    step(1'b0, '0, -1, 1'b0);
    step(1'b0, '0, -1, 1'b0);

    for (int i = 0; i < 400; i++) begin
      mode  = $urandom_range(0, 3);
      v_rnd = ($urandom_range(0, 3) != 0);
      base  = $urandom_range(20, 235);
      lo    = $urandom_range(0, 255);
      hi    = $urandom_range(0, 255);
      for (int k = 0; k < 9; k++) begin
        case (mode)
          0: w_rnd[k*8 +: 8] = 8'($urandom_range(0, 255));
          1: w_rnd[k*8 +: 8] = 8'(base + $urandom_range(0, 14) - 7);
          2: w_rnd[k*8 +: 8] = $urandom_range(0, 1) ? 8'(hi) : 8'(lo);
          default: begin
            w_rnd[k*8 +: 8] = 8'(base + $urandom_range(0, 130) - 65 < 0 ? 0 :
                              (base + $urandom_range(0, 130) - 65 > 255 ? 255 : base + $urandom_range(0, 130) - 65));
          end
        endcase
      end
      if (mode == 3) w_rnd[39:32] = 8'(base);
      step(v_rnd, w_rnd, -1, mode == 1);
    end
    step(1'b0, '0, -1, 1'b0);
    step(1'b0, '0, -1, 1'b0);

    step(1'b1, w_noise, 100, 1'b1);
    step(1'b1, w_sharp, 200, 1'b0);
    step(1'b1, w_nedge, 199, 1'b0);
    step(1'b1, w_weak, -1, 1'b0);
    step(1'b0, '0, -1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_valid", 72'(filter_valid), 72'(0));
    check_eq("midrst_window", window_filtered, 72'(0));
    @(posedge clk);
    @(negedge clk);
    check_eq("inrst_valid", 72'(filter_valid), 72'(0));
    rst_n = 1'b1;
    clear_hist();
    step(1'b0, '0, -1, 1'b0);
    step(1'b0, '0, -1, 1'b0);
    step(1'b0, '0, -1, 1'b0);
    step(1'b0, '0, -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bilateral_filter.md
Name: bilateral_filter

Overview:
- Edge-preserving 3x3 smoothing stage for the Sobel pre-filter path, used as a drop-in alternative to gaussian_blur; same window interface.
- Each neighbour weight = fixed 1-2-1 spatial Gaussian weight × a range weight set by the neighbour's intensity distance from the centre pixel.
- Pixels across a strong edge get zero weight, so edges survive while small noise is averaged out.
- Only the centre pixel of the window is replaced; the rest pass through.

Parameters:
PIXEL_WIDTH, 8, bits per pixel.
SIGMA_RANGE, 30, intensity-distance scale for the range weight; legal range 1..2^PIXEL_WIDTH-1.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
window_valid  input  1  window_flat is valid this cycle.
window_flat  input  9*PIXEL_WIDTH  3x3 window; pixel k at bits [k*PIXEL_WIDTH +: PIXEL_WIDTH]; k = row*3+col from top-left (p0); centre is p4.
filter_valid  output  1  one-cycle pulse: window_filtered updated.
window_filtered  output  9*PIXEL_WIDTH  input window with p4 replaced by the filtered value; p0-p3 and p5-p8 passed through unchanged.

Behaviour:
- Reset (async assert, sync deassert): filter_valid=0, window_filtered=0, all pipeline valids and registers cleared. Reset mid-operation drops in-flight windows; no output pulse for them.
- Pipeline, 2 stages, fully pipelined, one window per clock accepted:
  - Edge N samples window_valid=1.
  - Edge N+1: filter_valid=1, window_filtered holds the result.
  - filter_valid is high for exactly one cycle per accepted window.
  - Back-to-back valids give back-to-back results.
  - window_filtered holds its last value while no new result arrives.
- No backpressure; no ready signal.
- Spatial weights s_k: corners (p0,p2,p6,p8)=1; edges (p1,p3,p5,p7)=2; centre p4=4.
- Range weights, with d_k=|p_k - p4| computed unsigned and all comparisons widened so 2*SIGMA_RANGE cannot overflow:
  - 2*d < SIGMA_RANGE → r=4.
  - else d < SIGMA_RANGE → r=2.
  - else d < 2*SIGMA_RANGE → r=1.
  - else r=0.
  - Centre always has r=4 (d=0).
- Weight w_k = s_k*r_k, range 0..16.
- Accumulators:
  - W = sum of w_k; 7-bit, maximum 64.
  - S = sum of w_k*p_k; PIXEL_WIDTH+6 bits, maximum 64*255.
- Output: floor((S + floor(W/2)) / W), i.e. round-half-up, clamped to 2^PIXEL_WIDTH-1.
- W≥16 always, because the centre alone contributes 16. Division by zero is impossible; if W==0 ever occurs, output p4.
- Stage 1 registers weights and products (or partial sums). Stage 2 performs the division and registers the outputs.
- gaussian_blur (sibling, same ports, blur_valid/window_blurred) produces (sum s_k*p_k + 8) >> 4 with the same latency. For any window with all d_k < SIGMA_RANGE/2, bilateral and Gaussian results must be equal.

Decomposition:
- Shared package filter_pkg holds:
  - spatial kernel constants (1,2,1 / 2,4,2 / 1,2,1, shift 4);
  - range weight codes 4/2/1/0;
  - pixel index constants (CENTER_IDX=4);
  - a range_weight(d, sigma) function.
- One sub-module is natural: bilateral_div. It is a combinational unsigned divider, (PIXEL_WIDTH+6)-bit numerator / 7-bit denominator with rounding and clamp, instantiated in stage 2.

Test Plan:
- Uniform window, all 100, one valid pulse → filter_valid one cycle after the sampling edge; centre 100; Gaussian 100; other pixels unchanged.
- Noise window p8..p0 = 105,98,102,97,100,103,99,101,96 → bilateral 100, Gaussian 100.
- Sharp edge p8..p0 = 50,50,50,50,200,200,50,200,200 → bilateral 200 (all 50s weigh 0); Gaussian 134.
- Noisy edge p8..p0 = 48,52,51,49,198,202,53,197,201 → bilateral 199 (W=36, S=7164); Gaussian 134.
- Weak edge p8..p0 = 100,100,100,100,130,130,100,130,130, SIGMA 30 → bilateral 125 (W=43); Gaussian 117.
- Back-to-back valids over 3 cycles, then assert rst_n=0 mid-stream → 3 consecutive filter_valid pulses in order; after reset, filter_valid=0 and window_filtered=0 immediately.
